// File: rtl/cla_sub_iter_pkg.sv
// Shared state encoding and sizing helpers for the iterative CLA subtractor.
package cla_sub_iter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_N     = 32;
  localparam int unsigned DEF_W     = 8;
  localparam int unsigned DEF_NSTEP = DEF_N / DEF_W;

  // Slice counter needs at least one bit even when a single slice covers N.
  function automatic int unsigned cnt_width(input int unsigned nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead adder slice: s = a + b + cin.
module cla_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] w_g;
  logic [W-1:0] w_p;
  logic [W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Each carry is the flat sum-of-products of generates and propagates,
  // so no carry depends on a previously computed carry.
  always_comb begin
    logic w_prop;
    w_c    = '0;
    w_c[0] = cin;
    for (int unsigned i = 0; i < W; i++) begin
      w_prop = cin;
      for (int unsigned k = 0; k <= i; k++) w_prop = w_prop & w_p[k];
      w_c[i+1] = w_prop;
      for (int unsigned j = 0; j <= i; j++) begin
        w_prop = w_g[j];
        for (int unsigned k = j + 1; k <= i; k++) w_prop = w_prop & w_p[k];
        w_c[i+1] = w_c[i+1] | w_prop;
      end
    end
  end

  assign s    = w_p ^ w_c[W-1:0];
  assign cout = w_c[W];

endmodule

// File: rtl/cla_sub_iter.sv
// Iterative subtractor o_d = i_a - i_b - i_bw, one W-bit CLA slice per clock.
// Optional signed-overflow output o_ov is enabled by defining SUB_OVF_EN.
module cla_sub_iter
  import cla_sub_iter_pkg::*;
#(
  parameter int unsigned N = DEF_N,
  parameter int unsigned W = DEF_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_bw,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_d,
  output logic         o_bw
`ifdef SUB_OVF_EN
  ,
  output logic         o_ov
`endif
);

  localparam int unsigned NSTEP = N / W;
  localparam int unsigned CW    = cnt_width(NSTEP);

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_bn;
  logic [N-1:0]  r_d;
  logic          r_carry;
  logic          r_bw;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_sa;
  logic [W-1:0]  w_sb;
  logic [W-1:0]  w_s;
  logic          w_cout;
  logic          w_last;

  // Subtraction as a + ~b + ~bw; the stored subtrahend is already inverted.
  assign w_sa   = r_a[int'(r_cnt)*W +: W];
  assign w_sb   = r_bn[int'(r_cnt)*W +: W];
  assign w_last = (r_cnt == CW'(NSTEP - 1));

  cla_slice #(.W(W)) u_slice (
    .a    (w_sa),
    .b    (w_sb),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_valid) w_next = S_CALC;
      S_CALC:  if (w_last)  w_next = S_DONE;
      S_DONE:  if (i_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_bn    <= '0;
      r_d     <= '0;
      r_carry <= 1'b0;
      r_bw    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_a     <= i_a;
            r_bn    <= ~i_b;
            r_carry <= ~i_bw;
            r_cnt   <= '0;
          end
        end
        S_CALC: begin
          r_d[int'(r_cnt)*W +: W] <= w_s;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) r_bw <= ~w_cout;
        end
        default: ;
      endcase
    end
  end

`ifdef SUB_OVF_EN
  logic r_ov;

  // b's sign is ~r_bn[N-1], so "signs differ" becomes r_a == r_bn at the MSB.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ov <= 1'b0;
    end else if (r_state == S_CALC && w_last) begin
      r_ov <= (r_a[N-1] == r_bn[N-1]) & (w_s[W-1] != r_a[N-1]);
    end
  end

  assign o_ov = r_ov;
`endif

  assign o_ready = (r_state == S_IDLE);
  assign o_valid = (r_state == S_DONE);
  assign o_d     = r_d;
  assign o_bw    = r_bw;

endmodule

// File: tb/tb_cla_sub_iter.sv
// Scoreboard bench for cla_sub_iter; expectations are computed from operands at drive time.
module tb_cla_sub_iter;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_bw = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_d;
  logic        o_bw;
`ifdef SUB_OVF_EN
  logic        o_ov;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        bw;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  cla_sub_iter #(.N(32), .W(8)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_bw    (i_bw),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_d     (o_d),
    .o_bw    (o_bw)
`ifdef SUB_OVF_EN
    ,
    .o_ov    (o_ov)
`endif
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bw);
    exp_t        e;
    logic [32:0] u;
    logic [33:0] s;
    u = {1'b0, a} - {1'b0, b} - {32'd0, bw};
    s = {{2{a[31]}}, a} - {{2{b[31]}}, b} - {33'd0, bw};
    e.d  = u[31:0];
    e.bw = u[32];
    e.ov = (s[33:31] != 3'b000) && (s[33:31] != 3'b111);
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic bw);
    int n = 0;
    while (!o_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    i_bw = bw;
    sb.push_back(model(a, b, bw));
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_a  = $urandom;
    i_b  = $urandom;
    i_bw = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid(output int cyc, output bit timeout);
    cyc = 0;
    timeout = 1'b0;
    while (!o_valid) begin
      if (cyc >= 20) begin
        timeout = 1'b1;
        return;
      end
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_d !== 32'd0 || o_bw !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b d=%h bw=%b exp v=0 r=1 d=0 bw=0", o_valid, o_ready, o_d, o_bw);
    end
`ifdef SUB_OVF_EN
    checks++;
    if (o_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_ov got %b exp 0", o_ov);
    end
`endif
    @(negedge clk);
    i_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] va[5] = '{32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [31:0] vb[5] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h1234_5677, 32'h0BAD_F00D};
    logic        vw[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int cyc;
    bit to;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      send(va[i], vb[i], vw[i]);
      wait_valid(cyc, to);
      checks++;
      if (to || cyc != 4) begin
        errors++;
        $display("FAIL basic_latency[%0d] got %0d (timeout=%b) exp 4", i, cyc, to);
      end
      e = sb.pop_front();
      checks++;
      if (o_d !== e.d || o_bw !== e.bw) begin
        errors++;
        $display("FAIL basic_result[%0d] got d=%h bw=%b exp d=%h bw=%b", i, o_d, o_bw, e.d, e.bw);
      end
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      checks++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_release[%0d] got v=%b r=%b exp v=0 r=1", i, o_valid, o_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    bit to;
    exp_t e;
    logic [31:0] hold_d;
    logic        hold_bw;
    send(32'hFFFF_0000, 32'h0001_0001, 1'b0);
    wait_valid(cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || o_d !== e.d || o_bw !== e.bw) begin
      errors++;
      $display("FAIL bp_result got d=%h bw=%b exp d=%h bw=%b", o_d, o_bw, e.d, e.bw);
    end
    hold_d  = e.d;
    hold_bw = e.bw;
    for (int i = 0; i < 5; i++) begin
      i_valid = ~i_valid;
      i_a  = $urandom;
      i_b  = $urandom;
      i_bw = ~i_bw;
      @(posedge clk); #1;
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_d !== hold_d || o_bw !== hold_bw) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b d=%h bw=%b exp v=1 r=0 d=%h bw=%b",
                 i, o_valid, o_ready, o_d, o_bw, hold_d, hold_bw);
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", o_ready, o_valid);
    end
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    wait_valid(cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || o_d !== e.d || o_bw !== e.bw) begin
      errors++;
      $display("FAIL bp_next got d=%h bw=%b exp d=%h bw=%b", o_d, o_bw, e.d, e.bw);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit to;
    bit seen;
    exp_t e;
    i_valid = 1'b1;
    i_a = 32'hAAAA_5555;
    i_b = 32'h1111_2222;
    i_bw = 1'b0;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_d !== 32'd0 || o_bw !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got v=%b r=%b d=%h bw=%b exp v=0 r=1 d=0 bw=0", o_valid, o_ready, o_d, o_bw);
    end
    @(negedge clk);
    i_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_no_emit got o_valid=1 exp 0");
    end
    send(32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    wait_valid(cyc, to);
    e = sb.pop_front();
    checks++;
    if (to || o_d !== e.d || o_bw !== e.bw) begin
      errors++;
      $display("FAIL rst_after got d=%h bw=%b exp d=%h bw=%b", o_d, o_bw, e.d, e.bw);
    end
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    exp_t e;
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      wait_valid(cyc, to);
      checks++;
      if (to || sb.size() == 0) begin
        errors++;
        $display("FAIL b2b_timeout[%0d] got none exp result", i);
      end else begin
        e = sb.pop_front();
        checks++;
        if (o_d !== e.d || o_bw !== e.bw) begin
          errors++;
          $display("FAIL b2b_result[%0d] got d=%h bw=%b exp d=%h bw=%b", i, o_d, o_bw, e.d, e.bw);
        end
      end
    end
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

`ifdef SUB_OVF_EN
  task automatic test_ovf();
    logic [31:0] va[4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
    logic [31:0] vb[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000};
    logic        vw[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int cyc;
    bit to;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      send(va[i], vb[i], vw[i]);
      wait_valid(cyc, to);
      e = sb.pop_front();
      checks++;
      if (to || o_d !== e.d || o_ov !== e.ov) begin
        errors++;
        $display("FAIL ovf[%0d] got d=%h ov=%b exp d=%h ov=%b", i, o_d, o_ov, e.d, e.ov);
      end
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SUB_OVF_EN
    test_ovf();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
